// File: rtl/pc_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_trace_pkg
//  Description : Shared types and defaults for the PC trace FIFO: FSM state
//                encoding, default geometry and the stored entry layout.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_trace_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int PC_W_DEF  = 16;

  typedef enum logic [1:0] {
    CAPTURE  = 2'd0,
    FLUSH    = 2'd1,
    FINISHED = 2'd2
  } state_t;

  // Entry layout at default width. The memory stores the same packing
  // ({last, pc}) at the configured PC_W, so bit PC_W is always the last flag.
  typedef struct packed {
    logic                last;
    logic [PC_W_DEF-1:0] pc;
  } entry_t;

endpackage : pc_trace_pkg
`default_nettype wire

// File: rtl/pc_trace_mem.sv
`default_nettype none
// ============================================================================
//  Module      : pc_trace_mem
//  Description : DEPTH x (PC_W+1) register-array FIFO storage with wrapping
//                read/write pointers and an occupancy counter. Each entry is
//                packed as {last, pc}. Head entry is read straight out of the
//                register array, so read data is purely register-decoded.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                push, wr_last,    - write one entry at the tail
//                wr_pc
//                pop               - retire the head entry
//                merge_last        - set the last flag on the newest entry
//                rd_last, rd_pc    - head entry contents
//                full, empty       - occupancy flags
//                count             - occupancy 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module pc_trace_mem #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     wr_last,
  input  logic [PC_W-1:0]          wr_pc,
  input  logic                     pop,
  input  logic                     merge_last,
  output logic                     rd_last,
  output logic [PC_W-1:0]          rd_pc,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [PC_W:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic [AW-1:0]   newest;

  // Slot written most recently; wraps to DEPTH-1 when wr_ptr is 0.
  assign newest = wr_ptr - AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {wr_last, wr_pc};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      // Only requested when full with no pop, so it never collides with a push.
      if (merge_last) begin
        mem[newest][PC_W] <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_last = mem[rd_ptr][PC_W];
  assign rd_pc   = mem[rd_ptr][PC_W-1:0];
  assign full    = (cnt == C_FULL);
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule : pc_trace_mem
`default_nettype wire

// File: rtl/pc_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pc_trace_fifo
//  Description : Captures one PC sample per clock from the PC counter stage
//                into a FIFO and drains it over a valid/ready handshake. The
//                final (stop) PC is tagged with out_last; samples that arrive
//                while the FIFO is full are dropped and flagged by a sticky
//                overflow bit. If the final sample itself is dropped, the last
//                flag is merged onto the newest stored entry so the stream is
//                always terminated.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                pc_in, done_in        - PC stream from the counter stage
//                out_pc, out_valid,    - head entry and handshake to consumer
//                out_last, out_ready
//                count                 - occupancy 0..DEPTH
//                overflow              - sticky: a sample was dropped
//                idle                  - final sample has been consumed
//  Revision    : 1.0  initial release
// ============================================================================
module pc_trace_fifo
  import pc_trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     done_in,
  output logic [PC_W-1:0]          out_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     idle
);

  state_t              state;
  state_t              state_nxt;
  logic                overflow_r;

  logic                capture;
  logic                head_valid;
  logic                pop;
  logic                push;
  logic                drop;
  logic                merge_last;
  logic                full;
  logic                empty;
  logic                rd_last;
  logic [PC_W-1:0]     rd_pc;
  logic [$clog2(DEPTH):0] mem_count;

  // --------------------------------------------------------------------------
  // Push / pop qualification
  // --------------------------------------------------------------------------
  assign capture    = (state == CAPTURE);
  // Queued entries are never presented once the block is finished.
  assign head_valid = !empty && (state != FINISHED);
  assign pop        = head_valid && out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push       = capture && (!full || pop);
  assign drop       = capture && full && !pop;
  // Dropping the final sample must still terminate the stream.
  assign merge_last = drop && done_in;

  pc_trace_mem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .wr_last    (done_in),
    .wr_pc      (pc_in),
    .pop        (pop),
    .merge_last (merge_last),
    .rd_last    (rd_last),
    .rd_pc      (rd_pc),
    .full       (full),
    .empty      (empty),
    .count      (mem_count)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CAPTURE;
      overflow_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drop) begin
        overflow_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // The final sample leaves CAPTURE whether it was stored or merged.
      CAPTURE:  if (done_in)                state_nxt = FLUSH;
      FLUSH:    if (pop && rd_last)         state_nxt = FINISHED;
      FINISHED: state_nxt = FINISHED;
      default:  state_nxt = CAPTURE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (register-decoded only; out_ready never reaches them)
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_last  = 1'b0;
    if (head_valid) begin
      out_valid = 1'b1;
      out_pc    = rd_pc;
      out_last  = rd_last;
    end
  end

  assign count    = mem_count;
  assign overflow = overflow_r;
  assign idle     = (state == FINISHED);

endmodule : pc_trace_fifo
`default_nettype wire

// File: tb/tb_pc_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_trace_fifo
//  Description : Self-checking bench for pc_trace_fifo. A PC counter model
//                drives the stream; a queue-based reference model predicts
//                every output each cycle. Scenario checks cover the popped
//                sequence, last tagging, overflow and hold stability.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_trace_fifo;

  localparam int DEPTH = 8;
  localparam int PC_W  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PC_W-1:0] pc_in = '0;
  logic            done_in = 1'b0;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  logic            out_valid;
  logic            out_last;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            idle;

  always #5 clk = ~clk;

  pc_trace_fifo #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .done_in   (done_in),
    .out_pc    (out_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .count     (count),
    .overflow  (overflow),
    .idle      (idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of {pc,last} plus three flags.
  // --------------------------------------------------------------------------
  typedef struct {
    int pc;
    bit last;
  } ment_t;

  ment_t mq[$];
  bit    m_flush;
  bit    m_fin;
  bit    m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_flush = 0;
    m_fin   = 0;
    m_ovf   = 0;
  endfunction

  function automatic void model_edge(bit r, int pc, bit done, bit rdy);
    bit    pop;
    bit    do_push;
    ment_t e;
    if (r) begin
      model_reset();
      return;
    end
    pop     = (mq.size() > 0) && !m_fin && rdy;
    do_push = 0;
    if (!m_fin && !m_flush) begin
      if (mq.size() < DEPTH || pop) do_push = 1;
      else begin
        m_ovf = 1;
        if (done) mq[mq.size()-1].last = 1;
      end
      if (done) m_flush = 1;
    end
    if (pop) begin
      e = mq.pop_front();
      if (e.last) begin
        m_fin   = 1;
        m_flush = 0;
      end
    end
    if (do_push) mq.push_back('{pc, done});
  endfunction

  // --------------------------------------------------------------------------
  // Scenario runner.
  //   mode 0: ready=1   1: ready=0 until flushing   2: ready=0 for 8 cycles
  //   mode 3: random ready   4: ready toggles every cycle
  //   exp_hi >= 0: popped stream must be exactly 0..exp_hi
  //   exp_hi <  0: popped stream must be strictly increasing from 0
  // --------------------------------------------------------------------------
  task automatic run(input string name, input int stop, input int mode,
                     input int rst_at, input int exp_hi, input int exp_ovf);
    int              popped[$];
    bit              plast[$];
    int              pcv = 0;
    int              k = 0;
    int              tail = 0;
    bit              r;
    bit              dn;
    bit              rdy;
    bit              prev_hold = 0;
    logic [PC_W-1:0] prev_pc = '0;
    logic            prev_last = 1'b0;
    bit              ev;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      ev = (mq.size() > 0) && !m_fin;
      chk({name, ".valid"}, 32'(out_valid), 32'(ev));
      chk({name, ".pc"},    32'(out_pc),    ev ? 32'(mq[0].pc) : 32'd0);
      chk({name, ".last"},  32'(out_last),  ev ? 32'(mq[0].last) : 32'd0);
      chk({name, ".count"}, 32'(count),     32'(mq.size()));
      chk({name, ".ovf"},   32'(overflow),  32'(m_ovf));
      chk({name, ".idle"},  32'(idle),      32'(m_fin));
      if (prev_hold) begin
        chk({name, ".hold_pc"},   32'(out_pc),   32'(prev_pc));
        chk({name, ".hold_last"}, 32'(out_last), 32'(prev_last));
      end

      r  = (c < 2) || (c == rst_at);
      dn = (pcv == stop);
      case (mode)
        0:       rdy = 1;
        1:       rdy = m_flush || m_fin;
        2:       rdy = (k >= 8);
        3:       rdy = ($urandom % 2) == 1;
        default: rdy = k[0];
      endcase
      rst       = r;
      pc_in     = PC_W'(pcv);
      done_in   = dn;
      out_ready = rdy;

      if (r) begin
        popped.delete();
        plast.delete();
      end else if (out_valid && out_ready) begin
        popped.push_back(int'(out_pc));
        plast.push_back(out_last);
      end
      prev_hold = !r && out_valid && !out_ready;
      prev_pc   = out_pc;
      prev_last = out_last;

      @(posedge clk);
      model_edge(r, pcv, dn, rdy);
      if (r) begin
        pcv = 0;
        k   = 0;
      end else begin
        if (pcv < stop) pcv++;
        k++;
      end
      if (m_fin && !r) tail++;
      if (tail >= 3) break;
      if (c == 1999) chk({name, ".timeout"}, 32'd1, 32'd0);
    end
    rst       = 0;
    out_ready = 0;

    // Stream-level checks against the specification's expectations.
    if (exp_hi >= 0) begin
      chk({name, ".n_popped"}, 32'(popped.size()), 32'(exp_hi + 1));
      for (int i = 0; i < popped.size(); i++) begin
        chk({name, ".seq"}, 32'(popped[i]), 32'(i));
      end
    end else begin
      chk({name, ".first"}, (popped.size() > 0) ? 32'(popped[0]) : 32'hFFFF_FFFF, 32'd0);
      for (int i = 1; i < popped.size(); i++) begin
        chk({name, ".incr"}, 32'(popped[i] > popped[i-1]), 32'd1);
      end
    end
    for (int i = 0; i < plast.size(); i++) begin
      chk({name, ".lastpos"}, 32'(plast[i]), 32'(i == plast.size() - 1));
    end
    chk({name, ".idle_end"}, 32'(idle), 32'd1);
    chk({name, ".count_end"}, 32'(count), 32'd0);
    if (exp_ovf >= 0) chk({name, ".ovf_end"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    run("normal",     5,   0, -1, 5,   0);
    run("immediate",  0,   0, -1, 0,   0);
    run("backpress",  20,  1, -1, 7,   1);
    run("fullpop",    12,  2, -1, 12,  0);
    run("midreset",   30,  4, 10, -1, -1);
    run("stability",  100, 3, -1, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pc_trace_fifo
`default_nettype wire
